// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side handshake signals of the
// three-port memory arbiter.
//   master : arbiter view (takes requests, drives the memory command/beats)
//   slave  : environment view (requesters plus memory bridge)
// Requester fields are packed per port: port i lives at [i*W +: W].
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4
);
    // requester side
    logic [2:0]              req;
    logic [2:0]              req_write;
    logic [3*ADDR_WIDTH-1:0] req_addr;
    logic [3*LEN_WIDTH-1:0]  req_len;
    logic [3*DATA_WIDTH-1:0] req_wdata;
    logic [2:0]              addr_ok;
    logic [2:0]              data_ok;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    last;
    // memory side
    logic                    mem_req;
    logic                    mem_write;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [LEN_WIDTH-1:0]    mem_len;
    logic                    mem_addr_ok;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_wlast;
    logic                    mem_data_ok;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_last;

    modport master (
        input  req, req_write, req_addr, req_len, req_wdata,
        output addr_ok, data_ok, rdata, last,
        output mem_req, mem_write, mem_addr, mem_len, mem_wdata, mem_wlast,
        input  mem_addr_ok, mem_data_ok, mem_rdata, mem_last
    );

    modport slave (
        output req, req_write, req_addr, req_len, req_wdata,
        input  addr_ok, data_ok, rdata, last,
        input  mem_req, mem_write, mem_addr, mem_len, mem_wdata, mem_wlast,
        output mem_addr_ok, mem_data_ok, mem_rdata, mem_last
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external burst memory port between three
// miss-path requesters (0 icache refill, 1 dcache refill/writeback,
// 2 uncached). One burst in flight: IDLE arbitrates and latches the winner's
// command, ADDR presents it until mem_addr_ok, DATA counts beats to the end.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   bus           mem_port_arbiter_if.master (requester + memory handshakes)
//   protocol_err  sticky flag: read burst ended off the expected length
// The interface instance must use the same width parameters as this module.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic               clk,
    input  logic               resetn,
    mem_port_arbiter_if.master bus,
    output logic               protocol_err
);
    localparam int unsigned NPORTS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state;
    logic [1:0]            ptr;
    logic [1:0]            grant;
    logic [LEN_WIDTH-1:0]  cnt;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic                  win_valid;
    logic [1:0]            win_idx;
    logic [1:0]            cand;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [LEN_WIDTH-1:0]  win_len;
    logic [DATA_WIDTH-1:0] grant_wdata;
    logic [NPORTS-1:0]     grant_oh;
    logic                  in_addr;
    logic                  in_data;
    logic                  beat;
    logic                  cnt_at_len;
    logic                  final_beat;

    // Port visited k steps after base in the circular search order.
    function automatic logic [1:0] rr_port(input logic [1:0] base, input int unsigned k);
        int unsigned s;
        s = (32'(base) + k) % NPORTS;
        return 2'(s);
    endfunction

    // First requesting port starting from ptr wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            cand = rr_port(ptr, k);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_addr    = bus.req_addr[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len     = bus.req_len[32'(win_idx) * LEN_WIDTH +: LEN_WIDTH];
    assign grant_wdata = bus.req_wdata[32'(grant) * DATA_WIDTH +: DATA_WIDTH];
    assign grant_oh    = NPORTS'(1) << grant;

    assign in_addr    = (state == ADDR);
    assign in_data    = (state == DATA);
    // Beats outside DATA are strays and never reach a requester.
    assign beat       = in_data & bus.mem_data_ok;
    assign cnt_at_len = (cnt == cmd_len);
    // Writes end on the counted length; reads end on the memory's marker.
    assign final_beat = beat & (cmd_write ? cnt_at_len : bus.mem_last);

    // Command side is driven purely from latched fields.
    assign bus.mem_req   = in_addr;
    assign bus.mem_write = cmd_write;
    assign bus.mem_addr  = cmd_addr;
    assign bus.mem_len   = cmd_len;
    assign bus.mem_wdata = in_data ? grant_wdata : '0;
    assign bus.mem_wlast = in_data & cmd_write & cnt_at_len;

    // Handshake pulses pass straight through to the granted port only.
    assign bus.addr_ok = (in_addr & bus.mem_addr_ok) ? grant_oh : '0;
    assign bus.data_ok = beat ? grant_oh : '0;
    assign bus.rdata   = in_data ? bus.mem_rdata : '0;
    assign bus.last    = in_data & (cmd_write ? cnt_at_len : bus.mem_last);

    // Transaction sequencing, round-robin pointer and error tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            grant        <= 2'd0;
            cnt          <= '0;
            cmd_write    <= 1'b0;
            cmd_addr     <= '0;
            cmd_len      <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant     <= win_idx;
                        cmd_write <= bus.req_write[win_idx];
                        cmd_addr  <= win_addr;
                        cmd_len   <= win_len;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.mem_addr_ok) begin
                        cnt   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt <= cnt + LEN_WIDTH'(1);
                        if (!cmd_write && (bus.mem_last != cnt_at_len)) begin
                            protocol_err <= 1'b1;
                        end
                        if (final_beat) begin
                            state <= IDLE;
                            ptr   <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference
// model compared against every output on every falling clock edge.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic resetn;
    logic protocol_err;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit              m_busy  = 1'b0;   // a transaction owns the port
    bit              m_sent  = 1'b0;   // its command was accepted
    int              m_port  = 0;
    int              m_beats = 0;      // beats already transferred
    int              m_rr    = 0;      // port searched first next time
    bit              m_write = 1'b0;
    logic [AW-1:0]   m_addr  = '0;
    int              m_len   = 0;
    bit              m_err   = 1'b0;
    int              aok_cnt[3];
    int              dok_cnt[3];

    task automatic check_outputs();
        bit            in_cmd;
        bit            in_dat;
        bit            bt;
        logic [2:0]    oh;
        logic [DW-1:0] wd;
        in_cmd = m_busy && !m_sent;
        in_dat = m_busy && m_sent;
        bt     = in_dat && bus.mem_data_ok;
        oh     = 3'(1 << m_port);
        wd     = bus.req_wdata[m_port*DW +: DW];
        chk("mem_req",   64'(bus.mem_req),   64'(in_cmd));
        chk("mem_write", 64'(bus.mem_write), 64'(m_write));
        chk("mem_addr",  64'(bus.mem_addr),  64'(m_addr));
        chk("mem_len",   64'(bus.mem_len),   64'(m_len));
        chk("addr_ok",   64'(bus.addr_ok),   64'((in_cmd && bus.mem_addr_ok) ? oh : 3'b000));
        chk("data_ok",   64'(bus.data_ok),   64'(bt ? oh : 3'b000));
        chk("rdata",     64'(bus.rdata),     64'(in_dat ? bus.mem_rdata : '0));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(in_dat ? wd : '0));
        chk("mem_wlast", 64'(bus.mem_wlast), 64'(in_dat && m_write && (m_beats == m_len)));
        chk("last",      64'(bus.last),
            64'(in_dat && (m_write ? (m_beats == m_len) : bus.mem_last)));
        chk("protocol_err", 64'(protocol_err), 64'(m_err));
    endtask

    task automatic model_step();
        int p;
        bit fin;
        if (!resetn) begin
            m_busy = 0; m_sent = 0; m_port = 0; m_beats = 0; m_rr = 0;
            m_write = 0; m_addr = '0; m_len = 0; m_err = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 3; k++) begin
                p = (m_rr + k) % 3;
                if (!m_busy && bus.req[p]) begin
                    m_busy  = 1;
                    m_sent  = 0;
                    m_port  = p;
                    m_write = bus.req_write[p];
                    m_addr  = bus.req_addr[p*AW +: AW];
                    m_len   = int'(bus.req_len[p*LW +: LW]);
                end
            end
        end else if (!m_sent) begin
            if (bus.mem_addr_ok) begin
                m_sent  = 1;
                m_beats = 0;
            end
        end else if (bus.mem_data_ok) begin
            fin = m_write ? (m_beats == m_len) : bus.mem_last;
            if (!m_write && (bus.mem_last != (m_beats == m_len))) m_err = 1;
            m_beats++;
            if (fin) begin
                m_busy = 0;
                m_rr   = (m_port + 1) % 3;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            aok_cnt[i] = 0;
            dok_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            check_outputs();
            for (int i = 0; i < 3; i++) begin
                if (bus.addr_ok[i] === 1'b1) aok_cnt[i]++;
                if (bus.data_ok[i] === 1'b1) dok_cnt[i]++;
            end
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_port(input int p, input bit w, input logic [AW-1:0] a,
                            input int len, input logic [DW-1:0] wd);
        bus.req_write[p]           = w;
        bus.req_addr[p*AW +: AW]   = a;
        bus.req_len[p*LW +: LW]    = LW'(len);
        bus.req_wdata[p*DW +: DW]  = wd;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_mem_req();
        int n;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_mem_req", 64'(bus.mem_req), 64'(1));
    endtask

    // Accept the pending command, then return nbeats read beats.
    task automatic serve(input int nbeats, input int last_at, output int port);
        wait_mem_req();
        bus.mem_addr_ok = 1'b1;
        settle();
        port = -1;
        for (int i = 0; i < 3; i++) if (bus.addr_ok[i] === 1'b1) port = i;
        tick();
        bus.mem_addr_ok = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = 32'hC0DE_0000 + 32'(b);
            bus.mem_last    = (b == last_at);
            tick();
        end
        bus.mem_data_ok = 1'b0;
        bus.mem_last    = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int a0;
        int d0;
        int port;
        int exp_order[4];
        resetn          = 1'b0;
        bus.req         = '0;
        bus.req_write   = '0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.req_wdata   = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_last    = 1'b0;
        do_reset();

        // reset state
        chk("rst_mem_req",  64'(bus.mem_req),  64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_addr_ok",  64'(bus.addr_ok),  64'(0));
        chk("rst_err",      64'(protocol_err), 64'(0));

        // single read, port 0, len 3
        a0 = aok_cnt[0];
        d0 = dok_cnt[0];
        set_port(0, 1'b0, 32'h1FC0_0000, 3, '0);
        bus.req = 3'b001;
        settle();
        chk("t1_arb_cycle", 64'(bus.mem_req), 64'(0));
        tick();
        chk("t1_mem_req",  64'(bus.mem_req),  64'(1));
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'(32'h1FC0_0000));
        chk("t1_mem_len",  64'(bus.mem_len),  64'(3));
        tick();
        bus.mem_addr_ok = 1'b1;
        settle();
        chk("t1_addr_ok", 64'(bus.addr_ok), 64'(3'b001));
        tick();
        bus.mem_addr_ok = 1'b0;
        bus.req         = 3'b000;
        for (int b = 0; b < 4; b++) begin
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = 32'hD000_0000 + 32'(b);
            bus.mem_last    = (b == 3);
            settle();
            chk("t1_data_ok", 64'(bus.data_ok), 64'(3'b001));
            chk("t1_rdata",   64'(bus.rdata),   64'(32'hD000_0000 + 32'(b)));
            chk("t1_last",    64'(bus.last),    64'(b == 3));
            tick();
        end
        bus.mem_data_ok = 1'b0;
        bus.mem_last    = 1'b0;
        settle();
        chk("t1_idle_after", 64'(bus.mem_req), 64'(0));
        chk("t1_addr_ok_pulses", 64'(aok_cnt[0] - a0), 64'(1));
        chk("t1_data_ok_pulses", 64'(dok_cnt[0] - d0), 64'(4));
        // pointer moved past port 0: with 0 and 1 requesting, 1 wins
        set_port(1, 1'b0, 32'h0000_4000, 0, '0);
        bus.req = 3'b011;
        serve(1, 0, port);
        bus.req = 3'b000;
        chk("t1_ptr_is_1", 64'(port), 64'(1));

        // round robin from reset with all ports requesting
        do_reset();
        set_port(0, 1'b0, 32'h0000_0100, 0, '0);
        set_port(1, 1'b0, 32'h0000_0200, 0, '0);
        set_port(2, 1'b0, 32'h0000_0300, 0, '0);
        bus.req = 3'b111;
        exp_order[0] = 0;
        exp_order[1] = 1;
        exp_order[2] = 2;
        exp_order[3] = 0;
        for (int t = 0; t < 4; t++) begin
            serve(1, 0, port);
            chk("t2_rr_grant", 64'(port), 64'(exp_order[t]));
        end
        bus.req = 3'b000;

        // write burst, port 1, len 1
        d0 = dok_cnt[1];
        set_port(1, 1'b1, 32'h8000_1000, 1, 32'hAAAA_5555);
        bus.req = 3'b010;
        wait_mem_req();
        chk("t3_mem_write", 64'(bus.mem_write), 64'(1));
        bus.mem_addr_ok = 1'b1;
        tick();
        bus.mem_addr_ok = 1'b0;
        bus.req         = 3'b000;
        settle();
        chk("t3_wdata0", 64'(bus.mem_wdata), 64'(32'hAAAA_5555));
        chk("t3_wlast0", 64'(bus.mem_wlast), 64'(0));
        bus.mem_data_ok = 1'b1;
        settle();
        chk("t3_data_ok0", 64'(bus.data_ok), 64'(3'b010));
        tick();
        bus.req_wdata[1*DW +: DW] = 32'h1234_5678;
        settle();
        chk("t3_wdata1", 64'(bus.mem_wdata), 64'(32'h1234_5678));
        chk("t3_wlast1", 64'(bus.mem_wlast), 64'(1));
        chk("t3_last1",  64'(bus.last),      64'(1));
        tick();
        bus.mem_data_ok = 1'b0;
        settle();
        chk("t3_done",       64'(bus.mem_req),      64'(0));
        chk("t3_data_beats", 64'(dok_cnt[1] - d0),  64'(2));

        // command latch stable while ADDR stalls; stray beat ignored
        set_port(2, 1'b0, 32'hBFAF_0000, 0, '0);
        bus.req = 3'b100;
        wait_mem_req();
        bus.req_addr[2*AW +: AW] = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            bus.mem_data_ok = (i == 2);
            settle();
            chk("t4_mem_addr_hold", 64'(bus.mem_addr), 64'(32'hBFAF_0000));
            chk("t4_no_stray",      64'(bus.data_ok),  64'(0));
            tick();
        end
        bus.mem_data_ok = 1'b0;
        bus.mem_addr_ok = 1'b1;
        tick();
        bus.mem_addr_ok = 1'b0;
        bus.req         = 3'b000;
        bus.mem_data_ok = 1'b1;
        bus.mem_last    = 1'b1;
        tick();
        bus.mem_data_ok = 1'b0;
        bus.mem_last    = 1'b0;

        // read length mismatch: len 3, memory ends after 2 beats
        set_port(0, 1'b0, 32'h0000_2000, 3, '0);
        bus.req = 3'b001;
        serve(2, 1, port);
        bus.req = 3'b000;
        settle();
        chk("t5_port",     64'(port),         64'(0));
        chk("t5_err_set",  64'(protocol_err), 64'(1));
        chk("t5_idle",     64'(bus.mem_req),  64'(0));
        set_port(1, 1'b0, 32'h0000_3000, 0, '0);
        bus.req = 3'b010;
        serve(1, 0, port);
        bus.req = 3'b000;
        settle();
        chk("t5_err_sticky", 64'(protocol_err), 64'(1));

        // reset during beat 2 of a len 7 read on port 1
        set_port(1, 1'b0, 32'h0000_5000, 7, '0);
        bus.req = 3'b010;
        wait_mem_req();
        bus.mem_addr_ok = 1'b1;
        tick();
        bus.mem_addr_ok = 1'b0;
        bus.req         = 3'b000;
        bus.mem_data_ok = 1'b1;
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        settle();
        chk("t6_mem_req",  64'(bus.mem_req),  64'(0));
        chk("t6_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("t6_mem_len",  64'(bus.mem_len),  64'(0));
        chk("t6_data_ok",  64'(bus.data_ok),  64'(0));
        chk("t6_rdata",    64'(bus.rdata),    64'(0));
        chk("t6_err",      64'(protocol_err), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_stray_beat", 64'(bus.data_ok), 64'(0));
        end
        bus.mem_data_ok = 1'b0;
        // pointer back at 0: with ports 1 and 2 requesting, 1 wins
        set_port(1, 1'b0, 32'h0000_6000, 0, '0);
        set_port(2, 1'b0, 32'h0000_7000, 0, '0);
        bus.req = 3'b110;
        serve(1, 0, port);
        bus.req = 3'b000;
        chk("t6_ptr_reset", 64'(port), 64'(1));

        tick();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between three miss-path requesters: port 0 icache refill, port 1 dcache refill/writeback, port 2 uncached access.
- Sits below the cache/uncached units, above the bus bridge.
- Round-robin grant; one burst transaction in flight at a time.
- Latches the granted request's command fields and sequences the address phase, then counts data beats to completion.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data beat width
LEN_WIDTH, 4, burst length field; beats = len+1 (1..16)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
req  input  3  per-port request valid, held until that port's addr_ok
req_write  input  3  per-port 1=write, 0=read
req_addr  input  3*ADDR_WIDTH  per-port start address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_len  input  3*LEN_WIDTH  per-port beats-1
req_wdata  input  3*DATA_WIDTH  per-port current write beat
addr_ok  output  3  one-hot pulse: granted port's command accepted
data_ok  output  3  one-hot pulse: one beat transferred for granted port
rdata  output  DATA_WIDTH  read beat, valid with data_ok
last  output  1  final beat marker, valid with data_ok
mem_req  output  1  command valid to memory
mem_write  output  1  latched command direction
mem_addr  output  ADDR_WIDTH  latched command address
mem_len  output  LEN_WIDTH  latched command length
mem_addr_ok  input  1  memory accepted command
mem_wdata  output  DATA_WIDTH  write beat, taken from granted port
mem_wlast  output  1  high when the beat counter equals the latched len during a write
mem_data_ok  input  1  beat transferred (read returned or write accepted)
mem_rdata  input  DATA_WIDTH  read beat
mem_last  input  1  memory's final read beat marker
protocol_err  output  1  sticky: read burst length mismatch

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-low (resetn).
- States:
  - IDLE: no transaction in flight.
  - ADDR: command presented to memory, awaiting mem_addr_ok.
  - DATA: command accepted, counting beats.
- Reset:
  - State IDLE, round-robin pointer ptr=0, beat counter 0, grant 0.
  - Latched cmd fields 0, protocol_err 0.
  - All outputs 0; mem_wdata is 0 because no port is granted.
- IDLE:
  - Search order is ptr, ptr+1, ptr+2 (mod 3); the first port with req=1 wins.
  - At the clock edge: latch grant index, req_write, req_addr and req_len of the winner, then go to ADDR.
  - No req: stay in IDLE.
  - mem_req is never asserted in IDLE, so there is 1 cycle of arbitration latency.
- ADDR:
  - mem_req=1, driven from the latched fields.
  - Later changes on requester inputs do not affect mem_addr, mem_len or mem_write.
  - Cycle with mem_addr_ok=1: addr_ok[grant]=1 combinationally in that cycle; next state DATA; counter=0.
- DATA:
  - mem_req=0; mem_wdata = req_wdata of the granted port.
  - mem_data_ok passes through combinationally to data_ok[grant]; rdata=mem_rdata.
  - Each mem_data_ok increments the counter.
  - Write: last = mem_wlast = (counter==len).
  - Read: last = mem_last.
- Completion:
  - Condition: data_ok on the final beat (write: counter==len; read: mem_last).
  - Next state IDLE; ptr = (grant+1) mod 3.
  - Earliest next mem_req is 2 cycles after the final beat.
- protocol_err (reads only):
  - Set if mem_last=1 while counter!=len, or counter==len while mem_last=0.
  - The transaction still completes on mem_last.
  - Cleared only by reset.
- Unchanged by arrivals: new req on other ports during ADDR/DATA is ignored until IDLE. A granted port dropping req after grant does not abort the transaction.
- Outputs while ungranted:
  - addr_ok and data_ok are never asserted for a non-granted port.
  - Stray mem_data_ok in IDLE/ADDR is ignored: no output pulse, no counter change.
- Reset mid-transaction: back to IDLE, ptr=0, outputs 0 in the next cycle. In-flight memory beats after reset are ignored per the stray rule.
- Counter is LEN_WIDTH bits wide; len=15 gives 16 beats without counter overflow before completion.

Test Plan:
- Single read: port 0 req, addr=0x1FC0_0000, len=3; mem_addr_ok in the 2nd ADDR cycle; 4 mem_data_ok with mem_last on the 4th -> mem_req first high 1 cycle after req; addr_ok[0] one pulse; data_ok[0] 4 pulses with rdata passed through; last on beat 4; IDLE after; ptr=1.
- Round robin: ports 0,1,2 all requesting continuously, len=0 -> grant order 0,1,2,0; never the same port twice in a row.
- Write burst: port 1 write, len=1, wdata 0xAAAA_5555 then 0x1234_5678 -> mem_write=1; mem_wdata tracks port-1 data; mem_wlast=1 only on the 2nd beat; completion after 2 data_ok.
- Latch stability: port 2 changes req_addr 0xBFAF_0000 -> 0x0 while ADDR stalls 5 cycles -> mem_addr stays 0xBFAF_0000.
- Length mismatch: read len=3, mem_last on beat 2 -> protocol_err=1 (sticky); state IDLE after beat 2.
- Reset mid-burst: resetn low during beat 2 of a len=7 read -> next cycle all outputs 0, ptr=0; later mem_data_ok pulses produce no data_ok.
